// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg -- shared definitions for the frame streamer slice.
//
// Global frame/pixel macros (`FRAME_WIDTH, `FRAME_HEIGHT, `PIXEL_SIZE,
// `LOC_SIZE) normally come from the project's global.vh. Fallbacks are
// provided here, guarded by `ifndef, so a project-wide definition always
// wins. The FSM encodings `FS_IDLE / `FS_RUN / `FS_DRAIN live here as well.
//
// Optional feature macro used by frame_streamer: STREAMER_HBLANK_EN.

`ifndef FRAME_WIDTH
`define FRAME_WIDTH 640
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 480
`endif
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 10
`endif
`ifndef FS_IDLE
`define FS_IDLE 2'd0
`endif
`ifndef FS_RUN
`define FS_RUN 2'd1
`endif
`ifndef FS_DRAIN
`define FS_DRAIN 2'd2
`endif

package frame_streamer_pkg;

  localparam int FS_FRAME_W = `FRAME_WIDTH;
  localparam int FS_FRAME_H = `FRAME_HEIGHT;
  localparam int PIXEL_W    = `PIXEL_SIZE;
  localparam int LOC_W      = `LOC_SIZE;

  localparam logic [1:0] ST_IDLE  = `FS_IDLE;
  localparam logic [1:0] ST_RUN   = `FS_RUN;
  localparam logic [1:0] ST_DRAIN = `FS_DRAIN;

  // Bits needed to hold values 0..n (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo -- small synchronous FIFO with show-ahead head and occupancy.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset (clears contents)
//   push_i        write push_data_i this cycle
//   push_data_i   write data
//   pop_i         consume head this cycle (ignored when empty)
//   head_o        current head entry, valid whenever count_o != 0
//   count_o       number of stored entries (0..DEPTH)
//   empty_o       count_o == 0
//
// The owner guarantees a push never lands on a full FIFO unless a pop happens
// in the same cycle; in that case the write reuses the slot being freed.

module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          push_data_i,
  input  logic                           pop_i,
  output logic [DATA_WIDTH-1:0]          head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer -- raster source for the detection pixel stream.
//
// Reads one frame from a synchronous frame memory in raster order and emits
// one pixel per cycle (en/x/y/data) while honouring downstream stall. Reads
// are credit-limited so that everything in flight always fits in the local
// FIFO (DEPTH = RD_LATENCY+1), so a memory return is never dropped.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset (aborts frame)
//   start              pulse; begins one frame when idle, ignored while busy
//   stall              downstream not accepting this cycle
//   mem_addr, mem_rd   frame memory read request
//   mem_data           read data, valid RD_LATENCY cycles after mem_rd
//   en, x, y, data     pixel stream; en is high only when a pixel is taken
//   sof, eol, eof      frame/line markers, qualified by en
//   busy, done         frame in progress / one-cycle completion pulse
//
// Optional feature macro: STREAMER_HBLANK_EN -- when defined, en is held low
// for HBLANK cycles after every line except the last one.

module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int FRAME_W    = FS_FRAME_W,
  parameter int FRAME_H    = FS_FRAME_H,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 1,
  parameter int HBLANK     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [PIXEL_W-1:0] mem_data,
  output logic               en,
  output logic [LOC_W-1:0]   x,
  output logic [LOC_W-1:0]   y,
  output logic [PIXEL_W-1:0] data,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 1;

`ifdef STREAMER_HBLANK_EN
  localparam int BLANK_CYC = HBLANK;
`else
  // Without blanking the counter is never loaded and folds away.
  localparam int BLANK_CYC = 0 * HBLANK;
`endif
  localparam int BW = cnt_w(BLANK_CYC);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [LOC_W-1:0]  X_LAST    = LOC_W'(FRAME_W - 1);
  localparam logic [LOC_W-1:0]  Y_LAST    = LOC_W'(FRAME_H - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LOC_W-1:0]      x_q, x_d, y_q, y_d;
  logic [BW-1:0]         blank_q, blank_d;
  logic                  done_q, done_d;
  logic [RD_LATENCY-1:0] rd_sr_q;  // one bit per read still in the memory pipe
  logic [CW-1:0]         inflight, fifo_cnt;
  logic [OW-1:0]         occ;
  logic                  credit_ok, fifo_empty, push, rd;

  // Oldest read in the pipe returns this cycle.
  assign push = rd_sr_q[RD_LATENCY-1];

  stream_fifo #(
    .DATA_WIDTH(PIXEL_W),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(mem_data),
    .pop_i      (en),
    .head_o     (data),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(rd_sr_q[i]);
  end

  assign en  = ~fifo_empty & ~stall & (blank_q == '0);
  assign sof = en & (x_q == '0) & (y_q == '0);
  assign eol = en & (x_q == X_LAST);
  assign eof = eol & (y_q == Y_LAST);

  // Slots committed after this edge: buffered + in flight, less today's pop.
  assign occ       = OW'(fifo_cnt) + OW'(inflight) - OW'(en);
  assign credit_ok = (occ < OW'(DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd      = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      // Issuing the first read in the start cycle saves a cycle of latency.
      ST_IDLE:  rd = start & credit_ok;
      ST_RUN:   rd = credit_ok;
      ST_DRAIN: begin
        if ((inflight == '0) && (fifo_cnt == CW'(en))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (rd) begin
      if (addr_q == LAST_ADDR) begin
        addr_d  = '0;
        state_d = ST_DRAIN;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + LOC_W'(1);
      end else begin
        x_d = x_q + LOC_W'(1);
      end
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (en && eol && !eof)  blank_d = BW'(BLANK_CYC);
    else if (blank_q != '0) blank_d = blank_q - BW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= '0;
      done_q  <= 1'b0;
      rd_sr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      rd_sr_q <= RD_LATENCY'({rd_sr_q, rd});
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd;
  assign x        = x_q;
  assign y        = y_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
`timescale 1ns/1ps
module tb_frame_streamer;
  import frame_streamer_pkg::*;

  localparam int W       = 4;
  localparam int H       = 3;
  localparam int NPIX    = W * H;
  localparam int AW      = 19;
  localparam int RUN_CYC = 36;
`ifdef STREAMER_HBLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif

  typedef struct {
    logic [PIXEL_W-1:0] data;
    logic [LOC_W-1:0]   x, y;
    logic               sof, eol, eof;
    int                 cyc;
  } pix_t;

  // inputs: sel (0: RD_LATENCY=1, 1: RD_LATENCY=3), stalled pixel, stall
  // length, restart cycle; expected: first en cycle, done cycle (from start)
  typedef struct {
    int sel, spix, slen, rstrt, efirst, edone;
  } scen_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start_x = 1'b0, stall_on = 1'b0, sel = 1'b0;
  int   cyc = 0, checks = 0, errors = 0;
  int   t0, first_en, done_cyc, n_done, n_en, stall_rd, outst;
  pix_t exq[$];
  scen_t tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic               start_a, stall_a, rd_a, en_a, sof_a, eol_a, eof_a, busy_a, done_a;
  logic [AW-1:0]      addr_a;
  logic [PIXEL_W-1:0] mdata_a, data_a;
  logic [LOC_W-1:0]   x_a, y_a;
  logic               start_b, stall_b, rd_b, en_b, sof_b, eol_b, eof_b, busy_b, done_b;
  logic [AW-1:0]      addr_b;
  logic [PIXEL_W-1:0] mdata_b, data_b;
  logic [LOC_W-1:0]   x_b, y_b;

  assign start_a = start_x & ~sel;
  assign stall_a = stall_on & ~sel;
  assign start_b = start_x & sel;
  assign stall_b = stall_on & sel;

  // Frame memory models: mem[a] = a, fixed read latency.
  logic [PIXEL_W-1:0] pa0, pb0, pb1, pb2;
  always @(posedge clk) begin
    pa0 <= addr_a[PIXEL_W-1:0];
    pb0 <= addr_b[PIXEL_W-1:0];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mdata_a = pa0;
  assign mdata_b = pb2;

  frame_streamer #(.FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .RD_LATENCY(1), .HBLANK(2)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .stall(stall_a),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(mdata_a),
    .en(en_a), .x(x_a), .y(y_a), .data(data_a),
    .sof(sof_a), .eol(eol_a), .eof(eof_a), .busy(busy_a), .done(done_a));

  frame_streamer #(.FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .RD_LATENCY(3), .HBLANK(2)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .stall(stall_b),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(mdata_b),
    .en(en_b), .x(x_b), .y(y_b), .data(data_b),
    .sof(sof_b), .eol(eol_b), .eof(eof_b), .busy(busy_b), .done(done_b));

  // View of whichever DUT the current scenario drives.
  logic               rd_m, en_m, sof_m, eol_m, eof_m, busy_m, done_m;
  logic [PIXEL_W-1:0] data_m;
  logic [LOC_W-1:0]   x_m, y_m;
  int                 dep;
  assign rd_m   = sel ? rd_b   : rd_a;
  assign en_m   = sel ? en_b   : en_a;
  assign sof_m  = sel ? sof_b  : sof_a;
  assign eol_m  = sel ? eol_b  : eol_a;
  assign eof_m  = sel ? eof_b  : eof_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign data_m = sel ? data_b : data_a;
  assign x_m    = sel ? x_b    : x_a;
  assign y_m    = sel ? y_b    : y_a;
  assign dep    = sel ? 4 : 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    pix_t e;
    if (rst) begin
      outst = 0;
    end else begin
      if (rd_m) chk("credit_limit", (outst + 1 - int'(en_m)) <= dep, 1);
      outst = outst + int'(rd_m) - int'(en_m);
      if (stall_on && rd_m) stall_rd++;
      if (stall_on && exq.size() > 0) begin
        chk("stall_en_low", en_m, 0);
        chk("stall_hold_data", data_m, exq[0].data);
        chk("stall_hold_x", x_m, exq[0].x);
      end
      if (en_m) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
        if (exq.size() == 0) begin
          chk("unexpected_en", 1, 0);
        end else begin
          e = exq.pop_front();
          chk("pix_cycle", cyc - t0, e.cyc - t0);
          chk("pix_data", data_m, e.data);
          chk("pix_x", x_m, e.x);
          chk("pix_y", y_m, e.y);
          chk("pix_sof", sof_m, e.sof);
          chk("pix_eol", eol_m, e.eol);
          chk("pix_eof", eof_m, e.eof);
        end
      end
      if (done_m) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_low_at_done", busy_m, 0);
      end
    end
  end

  task automatic clear_stats();
    t0 = cyc; first_en = -1; done_cyc = -1; n_done = 0; n_en = 0; stall_rd = 0;
  endtask

  task automatic push_frame(input int f0, input int spix, input int slen);
    pix_t e;
    for (int p = 0; p < NPIX; p++) begin
      e.data = PIXEL_W'(p);
      e.x    = LOC_W'(p % W);
      e.y    = LOC_W'(p / W);
      e.sof  = (p == 0);
      e.eol  = ((p % W) == W - 1);
      e.eof  = (p == NPIX - 1);
      e.cyc  = t0 + f0 + p + BLK * (p / W) + ((spix >= 0 && p >= spix) ? slen : 0);
      exq.push_back(e);
    end
  endtask

  task automatic run_scen(input scen_t sc);
    int f0, hs;
    f0 = (sc.sel != 0) ? 4 : 2;
    hs = f0 + sc.spix + BLK * (sc.spix / W);
    @(posedge clk); #1;
    sel = (sc.sel != 0);
    clear_stats();
    push_frame(f0, sc.spix, sc.slen);
    for (int r = 0; r < RUN_CYC; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      if (r == 1) chk("busy_after_start", busy_m, 1);
      start_x  = (r == 0) || (sc.rstrt > 0 && r == sc.rstrt);
      stall_on = (sc.spix >= 0) && (r >= hs) && (r < hs + sc.slen);
    end
    start_x = 1'b0; stall_on = 1'b0;
    chk("first_en", first_en - t0, sc.efirst);
    chk("done_cycle", done_cyc - t0, sc.edone);
    chk("done_count", n_done, 1);
    chk("en_count", n_en, NPIX);
    chk("sb_empty", exq.size(), 0);
    if (sc.spix >= 0) chk("stall_reads_le_depth", stall_rd <= dep, 1);
    exq.delete();
  endtask

  initial begin
    tbl[0] = '{0, -1, 0, 0, 2, 14 + 2*BLK};
    tbl[1] = '{0,  5, 3, 0, 2, 17 + 2*BLK};
    tbl[2] = '{0,  0, 2, 0, 4, 16 + 2*BLK};
    tbl[3] = '{0, 11, 2, 0, 2, 16 + 2*BLK};
    tbl[4] = '{0, -1, 0, 5, 2, 14 + 2*BLK};
    tbl[5] = '{1, -1, 0, 0, 4, 16 + 2*BLK};
    tbl[6] = '{1,  6, 4, 0, 4, 20 + 2*BLK};
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", en_a, 0);
    chk("rst_mem_rd", rd_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_sof", sof_a, 0);
    chk("rst_eof", eof_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_en", en_b, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_scen(tbl[i]);

    // Reset mid-frame with pixel 6 at the head of the stream.
    @(posedge clk); #1;
    sel = 1'b0;
    clear_stats();
    push_frame(2, -1, 0);
    start_x = 1'b1;
    for (int r = 0; r < 40 && n_en < 6; r++) begin
      @(posedge clk); #1;
      start_x = 1'b0;
    end
    start_x = 1'b0;
    chk("reach_pixel6", n_en >= 6, 1);
    rst = 1'b1;
    exq.delete();
    @(posedge clk); #1;
    chk("abort_en", en_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_x", x_a, 0);
    chk("abort_y", y_a, 0);
    rst = 1'b0;
    n_done = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_no_en", n_en, 6);
    run_scen(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
